soft_tbm_trigger_ctrl: RTL and testbench

//  Event scheduler in front of the soft TBM: merges software commands, an external trigger input,
//  a periodic trigger generator and an automatic cal->trg sequencer into the 5-bit one-hot event
//  bus consumed as trg_in_tbm ([0]syn [1]trg [2]rsr [3]rst [4]cal). Enforces one event per sync

---
 rtl/soft_tbm_trigger_ctrl_if.sv | 32 +++
 rtl/soft_tbm_trigger_ctrl.sv | 135 +++++++++++++
 tb/tb_soft_tbm_trigger_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/soft_tbm_trigger_ctrl_if.sv
// rtl/soft_tbm_trigger_ctrl_if.sv - control, request and event bus of the soft TBM trigger scheduler
interface soft_tbm_trigger_ctrl_if #(
    parameter int LOST_W = 8
);
    logic              sync;
    logic              enable;
    logic              sw_stb;
    logic [4:0]        sw_cmd;
    logic              ext_ena;
    logic              ext_trg;
    logic              per_ena;
    logic [15:0]       per_period;
    logic              cal_trg_ena;
    logic [7:0]        cal_trg_dly;
    logic [7:0]        min_gap;
    logic [4:0]        trg_out;
    logic              busy;
    logic [15:0]       trg_count;
    logic [LOST_W-1:0] lost_count;

    modport master (
        output sync, enable, sw_stb, sw_cmd, ext_ena, ext_trg, per_ena, per_period,
               cal_trg_ena, cal_trg_dly, min_gap,
        input  trg_out, busy, trg_count, lost_count
    );

    modport slave (
        input  sync, enable, sw_stb, sw_cmd, ext_ena, ext_trg, per_ena, per_period,
               cal_trg_ena, cal_trg_dly, min_gap,
        output trg_out, busy, trg_count, lost_count
    );
endinterface

// File: rtl/soft_tbm_trigger_ctrl.sv
// rtl/soft_tbm_trigger_ctrl.sv - merges sw/ext/periodic/cal->trg requests into one-hot TBM events per sync tick
module soft_tbm_trigger_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int LOST_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    soft_tbm_trigger_ctrl_if.slave  bus
);
    // event bus bit positions
    localparam int SYN = 0;
    localparam int TRG = 1;
    localparam int RSR = 2;
    localparam int RST = 3;
    localparam int CAL = 4;

    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   ext_prev;
    logic                   ext_hold;
    logic [4:0]             sw_hold;
    logic [4:0]             pend;
    logic [4:0]             trg_out;
    logic [7:0]             gap;
    logic [7:0]             cal_tmr;
    logic [15:0]            per_cnt;
    logic [15:0]            trg_count;
    logic [LOST_W-1:0]      lost;

    logic [4:0]        sw_src;
    logic              ext_src;
    logic [4:0]        sel;
    logic [7:0]        cal_d;
    logic              cancel;
    logic              cal_start;
    logic              cal_fire;
    logic              per_on;
    logic              per_fire;
    logic [2:0]        n_trg;
    logic [2:0]        lost_inc;
    logic [LOST_W:0]   lost_sum;
    logic [LOST_W-1:0] lost_next;
    logic [4:0]        pend_clr;
    logic [4:0]        pend_set;

    // Requests seen between ticks are parked here so a low sync never drops them.
    assign sw_src  = sw_hold | (bus.sw_stb ? bus.sw_cmd : 5'b0);
    assign ext_src = ext_hold | (bus.ext_ena & ext_sync[SYNC_STAGES-1] & ~ext_prev);

    always_comb begin
        sel = 5'b0;
        if (bus.enable && gap == 8'd0 && pend != 5'b0) begin
            if (pend[RST])      sel[RST] = 1'b1;
            else if (pend[RSR]) sel[RSR] = 1'b1;
            else if (pend[SYN]) sel[SYN] = 1'b1;
            else if (pend[CAL]) sel[CAL] = 1'b1;
            else                sel[TRG] = 1'b1;
        end
    end

    assign cal_d     = (bus.cal_trg_dly == 8'd0) ? 8'd1 : bus.cal_trg_dly;
    assign cancel    = sel[RST] | sel[RSR];
    assign cal_start = sel[CAL] & bus.cal_trg_ena;
    // Request fires one tick before the target so the pend register issues it on the target tick.
    assign cal_fire  = cal_start ? (cal_d == 8'd1) : (cal_tmr == 8'd1 && !cancel);
    assign per_on    = bus.per_ena && bus.per_period != 16'd0;
    assign per_fire  = per_on && per_cnt == bus.per_period - 16'd1;

    assign n_trg    = {2'b0, sw_src[TRG]} + {2'b0, ext_src} + {2'b0, per_fire} + {2'b0, cal_fire};
    assign lost_inc = (n_trg == 3'd0) ? 3'd0 :
                      (pend[TRG] && !sel[TRG]) ? n_trg : n_trg - 3'd1;
    assign lost_sum  = {1'b0, lost} + {{(LOST_W-2){1'b0}}, lost_inc};
    assign lost_next = lost_sum[LOST_W] ? {LOST_W{1'b1}} : lost_sum[LOST_W-1:0];

    assign pend_clr = sel | (sel[RST] ? 5'b10010 : 5'b0);
    assign pend_set = {sw_src[CAL], sw_src[RST], sw_src[RSR], n_trg != 3'd0, sw_src[SYN]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_sync <= '0;
            ext_prev <= 1'b0;
            ext_hold <= 1'b0;
            sw_hold  <= 5'b0;
        end else begin
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], bus.ext_trg};
            ext_prev <= ext_sync[SYNC_STAGES-1];
            if (bus.sync) begin
                ext_hold <= 1'b0;
                sw_hold  <= 5'b0;
            end else begin
                ext_hold <= ext_src;
                sw_hold  <= sw_src;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= 5'b0;
            trg_out   <= 5'b0;
            gap       <= 8'd0;
            cal_tmr   <= 8'd0;
            per_cnt   <= 16'd0;
            trg_count <= 16'd0;
            lost      <= '0;
        end else if (bus.sync) begin
            pend    <= (pend & ~pend_clr) | pend_set;
            trg_out <= sel;
            gap     <= (sel != 5'b0) ? bus.min_gap : (gap != 8'd0 ? gap - 8'd1 : gap);

            if (cal_start)
                cal_tmr <= cal_d - 8'd1;
            else if (cancel)
                cal_tmr <= 8'd0;
            else if (cal_tmr != 8'd0)
                cal_tmr <= cal_tmr - 8'd1;

            if (!per_on || per_fire)
                per_cnt <= 16'd0;
            else
                per_cnt <= per_cnt + 16'd1;

            if (sel[RST] || sel[SYN])
                trg_count <= 16'd0;
            else if (sel[TRG])
                trg_count <= trg_count + 16'd1;

            lost <= lost_next;
        end
    end

    assign bus.trg_out    = trg_out;
    assign bus.busy       = (pend != 5'b0) || (cal_tmr != 8'd0);
    assign bus.trg_count  = trg_count;
    assign bus.lost_count = lost;
endmodule

// File: tb/tb_soft_tbm_trigger_ctrl.sv
// tb/tb_soft_tbm_trigger_ctrl.sv - self-checking bench for soft_tbm_trigger_ctrl
module tb_soft_tbm_trigger_ctrl;
    logic clk = 1'b0;
    logic reset;

    soft_tbm_trigger_ctrl_if #(.LOST_W(8)) bus ();

    soft_tbm_trigger_ctrl #(.SYNC_STAGES(2), .LOST_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit       sync;
        bit       en;
        bit       stb;
        bit [4:0] cmd;
        bit [4:0] out;
        bit       busy;
        int       tcnt;
        int       lost;
    } vec_t;

    // reference model state: absolute tick numbers instead of down-counters
    bit [4:0] m_pend, m_held, m_out;
    int m_tick, m_next_ok, m_cal_due, m_per_ticks, m_tcnt, m_lost;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pend = 0; m_held = 0; m_out = 0;
        m_tick = 0; m_next_ok = 0; m_cal_due = -1; m_per_ticks = 0; m_tcnt = 0; m_lost = 0;
    endtask

    task automatic do_reset();
        bus.sync = 0; bus.enable = 0; bus.sw_stb = 0; bus.sw_cmd = 0;
        bus.ext_ena = 0; bus.ext_trg = 0; bus.per_ena = 0; bus.per_period = 0;
        bus.cal_trg_ena = 0; bus.cal_trg_dly = 0; bus.min_gap = 0;
        reset = 1;
        clk_step();
        clk_step();
        reset = 0;
        model_reset();
    endtask

    // One clock of the reference model using the inputs currently driven.
    task automatic model_step();
        int prio[5] = '{3, 2, 0, 4, 1};
        bit [4:0] iss;
        bit old_trg;
        int t, n, add, d;
        if (bus.sw_stb) m_held |= bus.sw_cmd;
        if (!bus.sync) return;
        m_tick++;
        t = m_tick;
        iss = 0;
        if (bus.enable && t >= m_next_ok && m_pend != 0) begin
            for (int k = 0; k < 5; k++)
                if (iss == 0 && m_pend[prio[k]]) iss[prio[k]] = 1'b1;
        end
        old_trg = m_pend[1];
        if (iss != 0) begin
            m_next_ok = t + int'(bus.min_gap) + 1;
            m_pend &= ~iss;
            if (iss[3]) begin m_pend[1] = 0; m_pend[4] = 0; end
            if (iss[3] || iss[2]) m_cal_due = -1;
            if (iss[4] && bus.cal_trg_ena) begin
                d = (bus.cal_trg_dly == 0) ? 1 : int'(bus.cal_trg_dly);
                m_cal_due = t + d - 1;
            end
            if (iss[3] || iss[0]) m_tcnt = 0;
            if (iss[1]) m_tcnt = (m_tcnt + 1) % 65536;
        end
        m_out = iss;
        n = m_held[1] ? 1 : 0;
        if (bus.per_ena && bus.per_period != 0) begin
            m_per_ticks++;
            if (m_per_ticks % int'(bus.per_period) == 0) n++;
        end else begin
            m_per_ticks = 0;
        end
        if (m_cal_due == t) begin n++; m_cal_due = -1; end
        if (n > 0) begin
            add = (old_trg && !iss[1]) ? n : n - 1;
            m_lost = (m_lost + add > 255) ? 255 : m_lost + add;
        end
        m_pend |= {m_held[4:2], n > 0, m_held[0]};
        m_held = 0;
    endtask

    task automatic cal_seq(input bit [7:0] dly, input int exp_diff);
        int cal_t, trg_t;
        do_reset();
        bus.min_gap = 3; bus.cal_trg_ena = 1; bus.cal_trg_dly = dly; bus.enable = 1; bus.sync = 1;
        bus.sw_stb = 1; bus.sw_cmd = 5'b10000;
        clk_step();
        bus.sw_stb = 0;
        cal_t = -1; trg_t = -1;
        for (int t = 2; t <= 40; t++) begin
            clk_step();
            if (bus.trg_out == 5'b10000 && cal_t < 0) cal_t = t;
            if (bus.trg_out == 5'b00010 && trg_t < 0) trg_t = t;
            if (cal_t >= 0 && t == cal_t + 1) check($sformatf("cal%0d_busy", dly), bus.busy, 1);
        end
        check($sformatf("cal%0d_seen", dly), cal_t, 2);
        check($sformatf("cal%0d_trg_diff", dly), trg_t - cal_t, exp_diff);
        check($sformatf("cal%0d_idle", dly), bus.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[20];
        int last, cnt, rel, n_trg, first_rel, nz;

        vt[0]  = '{1, 1, 1, 5'b10111, 5'b00000, 1, 0, 0};
        vt[1]  = '{1, 1, 0, 5'b00000, 5'b00100, 1, 0, 0};
        vt[2]  = '{1, 1, 0, 5'b00000, 5'b00001, 1, 0, 0};
        vt[3]  = '{0, 1, 0, 5'b00000, 5'b00001, 1, 0, 0};
        vt[4]  = '{1, 1, 0, 5'b00000, 5'b10000, 1, 0, 0};
        vt[5]  = '{1, 1, 0, 5'b00000, 5'b00010, 0, 1, 0};
        vt[6]  = '{1, 1, 0, 5'b00000, 5'b00000, 0, 1, 0};
        vt[7]  = '{1, 0, 1, 5'b00010, 5'b00000, 1, 1, 0};
        vt[8]  = '{0, 0, 1, 5'b00001, 5'b00000, 1, 1, 0};
        vt[9]  = '{1, 0, 0, 5'b00000, 5'b00000, 1, 1, 0};
        vt[10] = '{1, 0, 0, 5'b00000, 5'b00000, 1, 1, 0};
        vt[11] = '{1, 1, 0, 5'b00000, 5'b00001, 1, 0, 0};
        vt[12] = '{1, 1, 0, 5'b00000, 5'b00010, 0, 1, 0};
        vt[13] = '{1, 0, 1, 5'b00010, 5'b00000, 1, 1, 0};
        vt[14] = '{1, 0, 1, 5'b01000, 5'b00000, 1, 1, 0};
        vt[15] = '{1, 1, 0, 5'b00000, 5'b01000, 0, 0, 0};
        vt[16] = '{1, 1, 0, 5'b00000, 5'b00000, 0, 0, 0};
        vt[17] = '{1, 0, 1, 5'b00010, 5'b00000, 1, 0, 0};
        vt[18] = '{1, 0, 1, 5'b00010, 5'b00000, 1, 0, 1};
        vt[19] = '{1, 1, 0, 5'b00000, 5'b00010, 0, 1, 1};

        do_reset();
        reset = 1;
        #1;
        check("rst_trg_out", bus.trg_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_trg_count", bus.trg_count, 0);
        check("rst_lost", bus.lost_count, 0);
        do_reset();

        for (int i = 0; i < 20; i++) begin
            bus.sync = vt[i].sync; bus.enable = vt[i].en;
            bus.sw_stb = vt[i].stb; bus.sw_cmd = vt[i].cmd;
            clk_step();
            check($sformatf("vec%0d_out", i), bus.trg_out, vt[i].out);
            check($sformatf("vec%0d_busy", i), bus.busy, vt[i].busy);
            check($sformatf("vec%0d_tcnt", i), bus.trg_count, vt[i].tcnt);
            check($sformatf("vec%0d_lost", i), bus.lost_count, vt[i].lost);
        end

        // periodic generator, period 10
        do_reset();
        bus.min_gap = 3; bus.per_period = 10; bus.per_ena = 1; bus.enable = 1; bus.sync = 1;
        last = -1; cnt = 0;
        for (int t = 1; t <= 45; t++) begin
            clk_step();
            if (bus.trg_out == 5'b00010) begin
                cnt++;
                check("per_tcnt", bus.trg_count, cnt);
                if (last < 0) check("per_first", t, 11);
                else          check("per_spacing", t - last, 10);
                last = t;
            end
        end
        check("per_events", cnt, 4);

        cal_seq(8'd20, 20);
        cal_seq(8'd2, 4);

        // external trigger while sync low, then lost merging inside a gap of 8
        do_reset();
        bus.ext_ena = 1; bus.min_gap = 8; bus.enable = 1; bus.sync = 0;
        bus.ext_trg = 1;
        clk_step();
        bus.ext_trg = 0;
        repeat (5) clk_step();
        check("ext_no_tick", bus.trg_out, 0);
        bus.sync = 1;
        clk_step();
        check("ext_pend_tick", bus.trg_out, 0);
        clk_step();
        check("ext_issue", bus.trg_out, 5'b00010);
        check("ext_tcnt", bus.trg_count, 1);
        rel = 0; n_trg = 0; first_rel = -1;
        for (int c = 0; c < 20; c++) begin
            bus.ext_trg = (c < 6) && (c % 2 == 0);
            clk_step();
            rel++;
            if (bus.trg_out == 5'b00010) begin
                n_trg++;
                if (first_rel < 0) first_rel = rel;
            end
        end
        bus.ext_trg = 0;
        check("ext_gap_trg_count", n_trg, 1);
        check("ext_gap_issue_tick", first_rel, 9);
        check("ext_lost", bus.lost_count, 2);

        // asynchronous reset in the middle of a running cal->trg sequence
        do_reset();
        bus.cal_trg_ena = 1; bus.cal_trg_dly = 20; bus.enable = 1; bus.sync = 1;
        bus.sw_stb = 1; bus.sw_cmd = 5'b10010;
        clk_step();
        bus.sw_stb = 0;
        clk_step();
        check("mid_cal", bus.trg_out, 5'b10000);
        clk_step();
        check("mid_trg", bus.trg_out, 5'b00010);
        check("mid_tcnt", bus.trg_count, 1);
        check("mid_busy", bus.busy, 1);
        #2;
        reset = 1;
        #1;
        check("mid_rst_out", bus.trg_out, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_tcnt", bus.trg_count, 0);
        clk_step();
        reset = 0;
        nz = 0;
        for (int c = 0; c < 25; c++) begin
            clk_step();
            if (bus.trg_out != 0) nz++;
        end
        check("mid_rst_no_event", nz, 0);

        // randomized traffic against the reference model
        for (int chunk = 0; chunk < 6; chunk++) begin
            do_reset();
            bus.min_gap     = 8'($urandom_range(0, 4));
            bus.cal_trg_ena = 1'($urandom_range(0, 1));
            bus.cal_trg_dly = 8'($urandom_range(0, 5));
            bus.per_ena     = 1'($urandom_range(0, 1));
            bus.per_period  = 16'($urandom_range(0, 7));
            for (int c = 0; c < 300; c++) begin
                bus.sync   = ($urandom_range(0, 1) == 1);
                bus.enable = ($urandom_range(0, 9) != 0);
                bus.sw_stb = ($urandom_range(0, 4) == 0);
                bus.sw_cmd = 5'($urandom);
                model_step();
                clk_step();
                check($sformatf("rnd%0d_%0d_out", chunk, c), bus.trg_out, m_out);
                check($sformatf("rnd%0d_%0d_busy", chunk, c), bus.busy,
                      (m_pend != 0 || m_cal_due > m_tick) ? 1 : 0);
                check($sformatf("rnd%0d_%0d_tcnt", chunk, c), bus.trg_count, m_tcnt);
                check($sformatf("rnd%0d_%0d_lost", chunk, c), bus.lost_count, m_lost);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
